// File: rtl/encoder_pkg.sv
// Shared widths and encode helpers for the registered 8-to-3 encoder.
package encoder_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

    // Returns {found, idx}. Later loop iterations overwrite earlier ones,
    // so the scan order decides which set bit wins.
    function automatic logic [ENC_OUT_W:0] enc_prio(input logic [ENC_IN_W-1:0] vec,
                                                    input logic                msb_first);
        logic                 found;
        logic [ENC_OUT_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < ENC_IN_W; i++) begin
            if (msb_first) begin
                if (vec[i]) begin
                    found = 1'b1;
                    idx   = ENC_OUT_W'(i);
                end
            end else if (vec[ENC_IN_W-1-i]) begin
                found = 1'b1;
                idx   = ENC_OUT_W'(ENC_IN_W - 1 - i);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [ENC_OUT_W:0] enc_popcnt(input logic [ENC_IN_W-1:0] vec);
        logic [ENC_OUT_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < ENC_IN_W; i++) begin
            cnt = cnt + {{ENC_OUT_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder_8to3_core.sv
// Purely combinational priority encoder: request vector to winning index.
module encoder_8to3_core
    import encoder_pkg::*;
(
    input  logic [ENC_IN_W-1:0]  in,
    input  logic                 msb_first,
    output logic [ENC_OUT_W-1:0] idx,
    output logic                 found
);

    assign {found, idx} = enc_prio(in, msb_first);

endmodule

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with sample enable and idle hold option.
// Define ENCODER_ONEHOT_CHECK_EN to add the registered multi-hot flag 'err'.
module encoder_8to3
    import encoder_pkg::*;
#(
    parameter int MSB_PRIORITY = 1,
    parameter int HOLD_ON_IDLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [ENC_IN_W-1:0]  in,
    output logic [ENC_OUT_W-1:0] out,
    output logic                 valid
`ifdef ENCODER_ONEHOT_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam logic MSB_FIRST = (MSB_PRIORITY != 0);
    localparam logic HOLD_IDLE = (HOLD_ON_IDLE != 0);

    logic [ENC_OUT_W-1:0] idx_p0;
    logic                 found_p0;
    logic [ENC_OUT_W-1:0] out_p1;
    logic                 vld_p1;

    encoder_8to3_core u_core (
        .in        (in),
        .msb_first (MSB_FIRST),
        .idx       (idx_p0),
        .found     (found_p0)
    );

    // p0 -> p1: output register; idle samples keep or clear the index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= found_p0;
            if (found_p0) begin
                out_p1 <= idx_p0;
            end else if (!HOLD_IDLE) begin
                out_p1 <= '0;
            end
        end
    end

    assign out   = out_p1;
    assign valid = vld_p1;

`ifdef ENCODER_ONEHOT_CHECK_EN
    logic err_p1;

    // Flag is only meaningful for the edge that sampled it; any other edge clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= en && (enc_popcnt(in) > (ENC_OUT_W+1)'(1));
        end
    end

    assign err = err_p1;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!err_p1)
            else $warning("encoder_8to3: multi-hot request vector was sampled");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// Scoreboard bench for encoder_8to3: default instance (MSB first, hold on idle)
// and an alternate instance (LSB first, clear on idle) driven from the same stimulus.
module tb_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] in_vec = 8'h00;
    logic [2:0] out_m, out_a;
    logic       valid_m, valid_a;
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic       err_m, err_a;
`endif

    encoder_8to3 #(.MSB_PRIORITY(1), .HOLD_ON_IDLE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in_vec),
        .out   (out_m),
        .valid (valid_m)
`ifdef ENCODER_ONEHOT_CHECK_EN
        ,
        .err   (err_m)
`endif
    );

    encoder_8to3 #(.MSB_PRIORITY(0), .HOLD_ON_IDLE(0)) dut_alt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in_vec),
        .out   (out_a),
        .valid (valid_a)
`ifdef ENCODER_ONEHOT_CHECK_EN
        ,
        .err   (err_a)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    out_m;
        int    valid_m;
        int    out_a;
        int    valid_a;
        int    err;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] vec;
        logic       en;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        check({e.name, ".out"},       int'(out_m),   e.out_m);
        check({e.name, ".valid"},     int'(valid_m), e.valid_m);
        check({e.name, ".alt_out"},   int'(out_a),   e.out_a);
        check({e.name, ".alt_valid"}, int'(valid_a), e.valid_a);
`ifdef ENCODER_ONEHOT_CHECK_EN
        check({e.name, ".err"},       int'(err_m),   e.err);
        check({e.name, ".alt_err"},   int'(err_a),   e.err);
`endif
    endtask

    // Monitor: one expectation per clock edge issued by the driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                check_all(sb_q.pop_front());
            end
        end
    end

    // name, in, en, {main out, main valid, alt out, alt valid, err}
    vec_t vecs[] = '{
        '{"oh80",    8'h80, 1'b1, '{"", 7, 1, 7, 1, 0}},
        '{"oh40",    8'h40, 1'b1, '{"", 6, 1, 6, 1, 0}},
        '{"oh20",    8'h20, 1'b1, '{"", 5, 1, 5, 1, 0}},
        '{"oh10",    8'h10, 1'b1, '{"", 4, 1, 4, 1, 0}},
        '{"oh08",    8'h08, 1'b1, '{"", 3, 1, 3, 1, 0}},
        '{"oh04",    8'h04, 1'b1, '{"", 2, 1, 2, 1, 0}},
        '{"oh02",    8'h02, 1'b1, '{"", 1, 1, 1, 1, 0}},
        '{"oh01",    8'h01, 1'b1, '{"", 0, 1, 0, 1, 0}},
        '{"prio26",  8'h26, 1'b1, '{"", 5, 1, 1, 1, 1}},
        '{"pre_idl", 8'h08, 1'b1, '{"", 3, 1, 3, 1, 0}},
        '{"idle",    8'h00, 1'b1, '{"", 3, 0, 0, 0, 0}},
        '{"set4",    8'h10, 1'b1, '{"", 4, 1, 4, 1, 0}},
        '{"gate0",   8'h01, 1'b0, '{"", 4, 1, 4, 1, 0}},
        '{"gate1",   8'h01, 1'b0, '{"", 4, 1, 4, 1, 0}},
        '{"gate2",   8'h01, 1'b0, '{"", 4, 1, 4, 1, 0}},
        '{"ungate",  8'h01, 1'b1, '{"", 0, 1, 0, 1, 0}},
        '{"single",  8'h40, 1'b1, '{"", 6, 1, 6, 1, 0}},
        '{"allset",  8'hFF, 1'b1, '{"", 7, 1, 0, 1, 1}},
        '{"gateff",  8'h00, 1'b0, '{"", 7, 1, 0, 1, 0}},
        '{"idle2",   8'h00, 1'b1, '{"", 7, 0, 0, 0, 0}},
        '{"ends81",  8'h81, 1'b1, '{"", 7, 1, 0, 1, 1}}
    };

    initial begin
        exp_t e;
        int   waited;

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        e = '{"por", 0, 0, 0, 0, 0};
        check_all(e);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            in_vec = vecs[i].vec;
            en     = vecs[i].en;
            e      = vecs[i].exp;
            e.name = vecs[i].name;
            sb_q.push_back(e);
        end

        // Let the scoreboard drain before the asynchronous reset
        @(negedge clk);
        en = 1'b0;
        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain1", sb_q.size(), 0);

        // Mid-cycle reset must clear outputs without a clock edge
        in_vec = 8'h80;
        en     = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        e = '{"rst_async", 0, 0, 0, 0, 0};
        check_all(e);
        @(posedge clk);
        #1;
        e = '{"rst_held", 0, 0, 0, 0, 0};
        check_all(e);

        @(negedge clk);
        rst_n = 1'b1;
        e = '{"post_rst", 7, 1, 7, 1, 0};
        sb_q.push_back(e);

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("drain2", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/encoder_8to3.md
Name: encoder_8to3

Overview:
- Registered 8-to-3 binary encoder: converts an 8-bit one-hot (or multi-hot) request vector into the 3-bit index of the winning bit.
- Combinational priority encode followed by an output register; one-cycle latency.
- Used as a generic index encoder in datapaths that produce one-hot selects (arbiter grants, decoder round-trips).

Parameters:
- MSB_PRIORITY, 1, 1 = highest-numbered set bit wins; 0 = lowest-numbered set bit wins.
- HOLD_ON_IDLE, 1, 1 = out holds its last value when no input bit is set; 0 = out clears to 3'd0 on idle.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, deassertion is synchronised externally
- en  input  1  sample enable; when low, all outputs hold
- in  input  8  request vector, bit i represents index i
- out  output  3  registered binary index of the winning bit
- valid  output  1  registered; 1 when the sampled vector had at least one bit set

Behaviour:
- Reset (rst_n=0, asynchronous): out=3'd0, valid=0; held while rst_n low regardless of clk/en.
- Latency: on rising clk with en=1, in is encoded and the result appears on out/valid after that edge (1 cycle). No combinational path from in to outputs.
- One-hot encoding: in=8'b1000_0000→7, 0100_0000→6, 0010_0000→5, 0001_0000→4, 0000_1000→3, 0000_0100→2, 0000_0010→1, 0000_0001→0.
- Multi-hot: MSB_PRIORITY=1 → index of highest set bit; MSB_PRIORITY=0 → index of lowest set bit. Never an OR of indices.
- All-zero input with en=1: valid←0; out holds previous value (HOLD_ON_IDLE=1) or ←3'd0 (HOLD_ON_IDLE=0).
- en=0: out and valid hold, including across an in change.
- Reset asserted mid-stream: outputs clear within the same cycle; first edge after release with en=1 encodes normally.
- No X propagation: an input bit at X/Z is a bench error, not a handled case.

Optional Feature:
- Macro ENCODER_ONEHOT_CHECK_EN.
- Defined: adds an output port err (1 bit, registered, reset 0). err←1 on any en=1 edge where popcount(in)>1; otherwise err←0. out/valid behaviour is unchanged (priority still applies). Also adds a simulation-only assertion that fires when err is set.
- Undefined: no err port, no checker logic; the remaining ports and timing are identical.

Decomposition:
- Package encoder_pkg:
  - ENC_IN_W=8, ENC_OUT_W=3.
  - Function enc_prio(vec, msb_first) returning {found, idx}.
  - Function enc_popcnt for the optional check.
- Sub-module encoder_8to3_core: purely combinational priority encoder (in, msb_first → idx, found).
- Top encoder_8to3 adds the en/reset output register, HOLD_ON_IDLE mux and the optional err logic.

Test Plan:
- Reset: rst_n=0 mid-cycle with in=8'h80 → out=0, valid=0 immediately; release, next edge → out=7, valid=1.
- One-hot sweep: in=8'h80,40,20,10,08,04,02,01, one per cycle, en=1 → out=7,6,5,4,3,2,1,0 each one cycle later, valid=1 throughout.
- Priority: in=8'b0010_0110 → out=5 (MSB_PRIORITY=1) and out=1 (MSB_PRIORITY=0); with ENCODER_ONEHOT_CHECK_EN defined, err=1.
- Idle: after in=8'h08 (out=3), apply in=8'h00 → valid=0; out=3 (HOLD_ON_IDLE=1) or out=0 (HOLD_ON_IDLE=0).
- Enable gating: out=4 registered, then en=0 with in=8'h01 for 3 cycles → out stays 4, valid stays 1; en=1 → out=0 next edge.
- Single-bit check: in=8'h40 with ENCODER_ONEHOT_CHECK_EN defined → err=0, out=6.
